// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline constants: opcodes, M-extension funct7, hazard FSM encodings
// and the ID-stage operand-use decode helpers.
package hazard_ctrl_pkg;

    localparam logic [6:0] MATHr   = 7'b0110011;
    localparam logic [6:0] MATHWr  = 7'b0111011;
    localparam logic [6:0] JAL     = 7'b1101111;
    localparam logic [6:0] BRANCH  = 7'b1100011;
    localparam logic [6:0] STORE   = 7'b0100011;
    localparam logic [6:0] LUI     = 7'b0110111;
    localparam logic [6:0] AUIPC   = 7'b0010111;
    localparam logic [6:0] LOAD    = 7'b0000011;
    localparam logic [6:0] F7_MEXT = 7'b0000001;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        LU_BUBBLE = 2'd1,
        MDU_WAIT  = 2'd2,
        FREEZE    = 2'd3
    } hz_state_e;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == JAL || op == LUI || op == AUIPC);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == MATHr) || (op == MATHWr) || (op == BRANCH) || (op == STORE);
    endfunction

    function automatic logic is_mext(input logic [6:0] op, input logic [6:0] f7);
        return ((op == MATHr) || (op == MATHWr)) && (f7 == F7_MEXT);
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register vector for in-flight MUL/DIV destinations; frozen while the
// data memory stalls the pipeline.
module hazard_scoreboard #(
    parameter int unsigned NREG = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mdu_issue,
    input  logic [4:0]      mdu_issue_rd,
    input  logic            mdu_done,
    input  logic [4:0]      mdu_done_rd,
    input  logic            freeze,
    output logic [NREG-1:0] busy
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_set;
    logic [NREG-1:0] w_clr;

    always_comb begin
        w_set = '0;
        w_clr = '0;
        for (int i = 0; i < int'(NREG); i++) begin
            if (mdu_issue && (mdu_issue_rd != 5'd0) && (i == int'(mdu_issue_rd))) begin
                w_set[i] = 1'b1;
            end
            if (mdu_done && (i == int'(mdu_done_rd))) begin
                w_clr[i] = 1'b1;
            end
        end
    end

    // Set is applied after clear so a fresh issue overrides an older completion.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= '0;
        end else if (!freeze) begin
            r_busy <= (r_busy & ~w_clr) | w_set;
        end
    end

    assign busy = r_busy;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, MUL/DIV data/structural hazards,
// redirect flushes and data-memory freeze, plus a stalled-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] IDinst,
    input  logic        EXmem_re,
    input  logic [4:0]  EXrd,
    input  logic        EXredirect,
    input  logic        dmem_stall,
    input  logic        mdu_issue,
    input  logic [4:0]  mdu_issue_rd,
    input  logic        mdu_done,
    input  logic [4:0]  mdu_done_rd,
    input  logic        mdu_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        idex_we,
    output logic        exmem_we,
    output logic        memwb_we,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [31:0] stall_cnt
);

    hz_state_e       r_state;
    hz_state_e       r_saved;
    hz_state_e       w_eff_state;
    logic [31:0]     r_stall_cnt;
    logic [NREG-1:0] w_busy;
    logic [31:0]     w_busy32;

    logic [6:0] w_op;
    logic [6:0] w_f7;
    logic [4:0] w_rs1;
    logic [4:0] w_rs2;
    logic [4:0] w_rd;
    logic       w_use1;
    logic       w_use2;
    logic       w_lu_hz;
    logic       w_mdu_hz;
    logic       w_unused_funct3;

    assign w_op            = IDinst[6:0];
    assign w_rd            = IDinst[11:7];
    assign w_rs1           = IDinst[19:15];
    assign w_rs2           = IDinst[24:20];
    assign w_f7            = IDinst[31:25];
    assign w_unused_funct3 = ^IDinst[14:12];
    assign w_use1          = uses_rs1(w_op);
    assign w_use2          = uses_rs2(w_op);

    hazard_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk          (clk),
        .rstn         (rstn),
        .mdu_issue    (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd),
        .mdu_done     (mdu_done),
        .mdu_done_rd  (mdu_done_rd),
        .freeze       (dmem_stall),
        .busy         (w_busy)
    );

    // Architectural view of the busy vector; x0 is never busy.
    always_comb begin
        w_busy32 = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(NREG)) w_busy32[i] = w_busy[i];
        end
        w_busy32[0] = 1'b0;
    end

    assign w_lu_hz = EXmem_re && (EXrd != 5'd0) &&
                     ((w_use1 && (w_rs1 == EXrd)) || (w_use2 && (w_rs2 == EXrd)));

    assign w_mdu_hz = (w_use1 && w_busy32[w_rs1]) || (w_use2 && w_busy32[w_rs2]) ||
                      w_busy32[w_rd] || (mdu_busy && is_mext(w_op, w_f7));

    always_comb begin
        pc_we      = 1'b1;
        ifid_we    = 1'b1;
        idex_we    = 1'b1;
        exmem_we   = 1'b1;
        memwb_we   = 1'b1;
        ifid_flush = 1'b0;
        idex_flush = 1'b0;
        if (!rstn) begin
            pc_we = 1'b1;
        end else if (dmem_stall) begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_we  = 1'b0;
            exmem_we = 1'b0;
            memwb_we = 1'b0;
        end else if (EXredirect) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_mdu_hz || w_lu_hz) begin
            pc_we      = 1'b0;
            ifid_we    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    // Leaving FREEZE resumes the saved state and is evaluated in the same cycle.
    assign w_eff_state = (r_state == FREEZE) ? r_saved : r_state;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= RUN;
            r_saved     <= RUN;
            r_stall_cnt <= '0;
        end else begin
            if (!pc_we) r_stall_cnt <= r_stall_cnt + 32'd1;
            if (dmem_stall) begin
                r_state <= FREEZE;
                if (r_state != FREEZE) r_saved <= r_state;
            end else if (EXredirect) begin
                r_state <= RUN;
                r_saved <= RUN;
            end else begin
                unique case (w_eff_state)
                    RUN:       r_state <= w_mdu_hz ? MDU_WAIT : (w_lu_hz ? LU_BUBBLE : RUN);
                    LU_BUBBLE: r_state <= RUN;
                    MDU_WAIT:  r_state <= w_mdu_hz ? MDU_WAIT : (w_lu_hz ? LU_BUBBLE : RUN);
                    default:   r_state <= RUN;
                endcase
            end
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [31:0] IDinst;
    logic        EXmem_re, EXredirect, dmem_stall;
    logic [4:0]  EXrd, mdu_issue_rd, mdu_done_rd;
    logic        mdu_issue, mdu_done, mdu_busy;
    logic        pc_we, ifid_we, idex_we, exmem_we, memwb_we, ifid_flush, idex_flush;
    logic [31:0] stall_cnt;
    logic [4:0]  en;
    logic [1:0]  fl;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] NOP = 32'h0000_0013;

    always #5 clk = ~clk;

    hazard_ctrl #(.NREG(32)) dut (
        .clk (clk), .rstn (rstn), .IDinst (IDinst), .EXmem_re (EXmem_re), .EXrd (EXrd),
        .EXredirect (EXredirect), .dmem_stall (dmem_stall), .mdu_issue (mdu_issue),
        .mdu_issue_rd (mdu_issue_rd), .mdu_done (mdu_done), .mdu_done_rd (mdu_done_rd),
        .mdu_busy (mdu_busy), .pc_we (pc_we), .ifid_we (ifid_we), .idex_we (idex_we),
        .exmem_we (exmem_we), .memwb_we (memwb_we), .ifid_flush (ifid_flush),
        .idex_flush (idex_flush), .stall_cnt (stall_cnt)
    );

    assign en = {pc_we, ifid_we, idex_we, exmem_we, memwb_we};
    assign fl = {ifid_flush, idex_flush};

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [4:0] rd,
                                          input logic [6:0] op);
        return {f7, rs2, rs1, 3'b000, rd, op};
    endfunction

    task automatic idle();
        IDinst = NOP; EXmem_re = 0; EXrd = 0; EXredirect = 0; dmem_stall = 0;
        mdu_issue = 0; mdu_issue_rd = 0; mdu_done = 0; mdu_done_rd = 0; mdu_busy = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rstn = 0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 0;
        dmem_stall = 1; EXmem_re = 1; EXrd = 5; IDinst = rtype(0, 1, 5, 6, MATHr);
        mdu_issue = 1; mdu_issue_rd = 3; EXredirect = 1;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL rst_en got=%b want=11111", en); end
        total++; if (fl !== 2'b00) begin bad++; $display("FAIL rst_fl got=%b want=00", fl); end
        @(negedge clk);
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt); end
        total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL rst_state got=%0d want=0", dut.r_state); end
        total++; if (dut.w_busy !== 32'h0) begin bad++; $display("FAIL rst_busy got=%h want=0", dut.w_busy); end
        idle();
        rstn = 1;
    endtask

    task automatic test_load_use();
        do_reset();
        EXmem_re = 1; EXrd = 5; IDinst = rtype(0, 1, 5, 6, MATHr);
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL lu_en got=%b want=00111", en); end
        total++; if (fl !== 2'b01) begin bad++; $display("FAIL lu_fl got=%b want=01", fl); end
        @(negedge clk);
        total++; if (dut.r_state !== LU_BUBBLE) begin bad++; $display("FAIL lu_state got=%0d want=1", dut.r_state); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt got=%0d want=1", stall_cnt); end
        EXmem_re = 0; EXrd = 0;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL lu_bub_en got=%b want=11111", en); end
        total++; if (fl !== 2'b00) begin bad++; $display("FAIL lu_bub_fl got=%b want=00", fl); end
        @(negedge clk);
        total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL lu_ret_state got=%0d want=0", dut.r_state); end
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL lu_cnt2 got=%0d want=1", stall_cnt); end
    endtask

    task automatic test_x0();
        do_reset();
        EXmem_re = 1; EXrd = 0; IDinst = rtype(0, 0, 0, 6, MATHr);
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL x0_en got=%b want=11111", en); end
        @(negedge clk);
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL x0_cnt got=%0d want=0", stall_cnt); end
        idle();
    endtask

    task automatic test_operand_decode();
        do_reset();
        EXmem_re = 1; EXrd = 5;
        IDinst = {7'b0, 5'd5, 5'd5, 3'b000, 5'd6, LUI};
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL dec_lui got=%b want=11111", en); end
        @(negedge clk);
        IDinst = {7'b0, 5'd5, 5'd5, 3'b000, 5'd6, JAL};
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL dec_jal got=%b want=11111", en); end
        @(negedge clk);
        IDinst = {7'b0, 5'd5, 5'd1, 3'b000, 5'd6, 7'b0010011};
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL dec_addi got=%b want=11111", en); end
        @(negedge clk);
        IDinst = {7'b0, 5'd5, 5'd1, 3'b010, 5'd0, STORE};
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL dec_sw got=%b want=00111", en); end
        @(negedge clk);
        EXmem_re = 0; EXrd = 0;
        @(negedge clk);
        total++; if (stall_cnt !== 32'd1) begin bad++; $display("FAIL dec_cnt got=%0d want=1", stall_cnt); end
        idle();
    endtask

    task automatic test_redirect();
        do_reset();
        EXmem_re = 1; EXrd = 5; IDinst = rtype(0, 1, 5, 6, MATHr); EXredirect = 1;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL rd_en got=%b want=11111", en); end
        total++; if (fl !== 2'b11) begin bad++; $display("FAIL rd_fl got=%b want=11", fl); end
        @(negedge clk);
        total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL rd_state got=%0d want=0", dut.r_state); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL rd_cnt got=%0d want=0", stall_cnt); end
        idle();
    endtask

    task automatic test_mdu();
        do_reset();
        mdu_issue = 1; mdu_issue_rd = 7; mdu_busy = 1;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL mdu_iss_en got=%b want=11111", en); end
        @(negedge clk);
        mdu_issue = 0;
        total++; if (dut.w_busy[7] !== 1'b1) begin bad++; $display("FAIL mdu_busy7 got=%b want=1", dut.w_busy[7]); end
        repeat (10) @(negedge clk);
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL mdu_nop_en got=%b want=11111", en); end
        IDinst = rtype(0, 2, 7, 8, MATHr);
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if (en !== 5'b00111) begin bad++; $display("FAIL mdu_wait_en%0d got=%b want=00111", i, en); end
            total++; if (fl !== 2'b01) begin bad++; $display("FAIL mdu_wait_fl%0d got=%b want=01", i, fl); end
            @(negedge clk);
            total++; if (dut.r_state !== MDU_WAIT) begin bad++; $display("FAIL mdu_state%0d got=%0d want=2", i, dut.r_state); end
        end
        mdu_done = 1; mdu_done_rd = 7; mdu_busy = 0;
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL mdu_done_en got=%b want=00111", en); end
        @(negedge clk);
        mdu_done = 0;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL mdu_after_en got=%b want=11111", en); end
        total++; if (fl !== 2'b00) begin bad++; $display("FAIL mdu_after_fl got=%b want=00", fl); end
        @(negedge clk);
        total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL mdu_ret_state got=%0d want=0", dut.r_state); end
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL mdu_cnt got=%0d want=5", stall_cnt); end
        idle();
    endtask

    task automatic test_mdu_struct();
        do_reset();
        mdu_busy = 1; IDinst = rtype(F7_MEXT, 12, 11, 10, MATHr);
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL st_mul_en got=%b want=00111", en); end
        @(negedge clk);
        mdu_busy = 0;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL st_free_en got=%b want=11111", en); end
        @(negedge clk);
        mdu_busy = 1; IDinst = rtype(0, 12, 11, 10, MATHr);
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL st_add_en got=%b want=11111", en); end
        IDinst = rtype(F7_MEXT, 12, 11, 10, MATHWr);
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL st_mulw_en got=%b want=00111", en); end
        @(negedge clk);
        idle();
        @(negedge clk);
        total++; if (stall_cnt !== 32'd2) begin bad++; $display("FAIL st_cnt got=%0d want=2", stall_cnt); end
    endtask

    task automatic test_collision();
        do_reset();
        mdu_issue = 1; mdu_issue_rd = 9; mdu_done = 1; mdu_done_rd = 9;
        @(negedge clk);
        mdu_issue = 0; mdu_done = 0;
        total++; if (dut.w_busy[9] !== 1'b1) begin bad++; $display("FAIL col_busy9 got=%b want=1", dut.w_busy[9]); end
        IDinst = rtype(0, 2, 1, 9, MATHr);
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL col_waw_en got=%b want=00111", en); end
        @(negedge clk);
        mdu_done = 1; mdu_done_rd = 9;
        @(negedge clk);
        mdu_done = 0;
        total++; if (dut.w_busy[9] !== 1'b0) begin bad++; $display("FAIL col_clr9 got=%b want=0", dut.w_busy[9]); end
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL col_free_en got=%b want=11111", en); end
        IDinst = NOP; mdu_issue = 1; mdu_issue_rd = 0;
        @(negedge clk);
        mdu_issue = 0;
        total++; if (dut.w_busy !== 32'h0) begin bad++; $display("FAIL col_x0 got=%h want=0", dut.w_busy); end
    endtask

    task automatic test_freeze_reset();
        do_reset();
        mdu_issue = 1; mdu_issue_rd = 7; mdu_busy = 1;
        @(negedge clk);
        mdu_issue = 0; IDinst = rtype(0, 2, 7, 8, MATHr);
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL fz_pre_en got=%b want=00111", en); end
        @(negedge clk);
        total++; if (dut.r_state !== MDU_WAIT) begin bad++; $display("FAIL fz_pre_state got=%0d want=2", dut.r_state); end
        dmem_stall = 1; mdu_done = 1; mdu_done_rd = 7;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (en !== 5'b00000) begin bad++; $display("FAIL fz_en%0d got=%b want=00000", i, en); end
            total++; if (fl !== 2'b00) begin bad++; $display("FAIL fz_fl%0d got=%b want=00", i, fl); end
            @(negedge clk);
            mdu_done = 0;
            total++; if (dut.r_state !== FREEZE) begin bad++; $display("FAIL fz_state%0d got=%0d want=3", i, dut.r_state); end
        end
        total++; if (dut.w_busy[7] !== 1'b1) begin bad++; $display("FAIL fz_busy7 got=%b want=1", dut.w_busy[7]); end
        total++; if (stall_cnt !== 32'd4) begin bad++; $display("FAIL fz_cnt got=%0d want=4", stall_cnt); end
        dmem_stall = 0;
        #1;
        total++; if (en !== 5'b00111) begin bad++; $display("FAIL fz_res_en got=%b want=00111", en); end
        @(negedge clk);
        total++; if (dut.r_state !== MDU_WAIT) begin bad++; $display("FAIL fz_res_state got=%0d want=2", dut.r_state); end
        total++; if (stall_cnt !== 32'd5) begin bad++; $display("FAIL fz_res_cnt got=%0d want=5", stall_cnt); end
        dmem_stall = 1;
        @(negedge clk);
        #1;
        rstn = 0;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL fzr_en got=%b want=11111", en); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL fzr_cnt got=%0d want=0", stall_cnt); end
        total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL fzr_state got=%0d want=0", dut.r_state); end
        total++; if (dut.w_busy !== 32'h0) begin bad++; $display("FAIL fzr_busy got=%h want=0", dut.w_busy); end
        @(negedge clk);
        dmem_stall = 0; rstn = 1;
        #1;
        total++; if (en !== 5'b11111) begin bad++; $display("FAIL fzr_post_en got=%b want=11111", en); end
        @(negedge clk);
        total++; if (dut.r_state !== RUN) begin bad++; $display("FAIL fzr_post_state got=%0d want=0", dut.r_state); end
        total++; if (stall_cnt !== 32'd0) begin bad++; $display("FAIL fzr_post_cnt got=%0d want=0", stall_cnt); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_x0();
        test_operand_decode();
        test_redirect();
        test_mdu();
        test_mdu_struct();
        test_collision();
        test_freeze_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
